store_buffer_v2: RTL
====================

Name: store_buffer_v2

Overview:
- Parametrised, byte-strobe store buffer between the LSU execute stage and the data bus.
- Holds stores in program order and marks them committed by ROB id.
- On flush, discards the uncommitted tail and keeps the committed prefix.
- Drains committed stores to the bus with a req/ack handshake and forwards byte-merged store data to load queries in the same cycle.

Parameters:
- DEPTH, 8, entry count; power of two, at least 2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, entry/bus data width in bits; multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
- ROB_ID_WIDTH, 7, ROB id width.
- COMMIT_WIDTH, 2, commit lanes per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- push_valid  in  1  store from LSU
- push_ready  out  1  = !full && !flush
- push_rob_id  in  ROB_ID_WIDTH  ROB id of store
- push_addr  in  ADDR_WIDTH  byte address; low log2(STRB_WIDTH) bits ignored (word aligned)
- push_strb  in  STRB_WIDTH  byte enables
- push_data  in  DATA_WIDTH  lane-aligned data
- query_addr  in  ADDR_WIDTH  load word address
- query_strb  in  STRB_WIDTH  load bytes
- fwd_data  out  DATA_WIDTH  forwarded bytes; zero where not hit
- fwd_hit_mask  out  STRB_WIDTH  bytes supplied by buffer (masked by query_strb)
- fwd_full_hit  out  1  query_strb != 0 and every queried byte hit
- commit_enable  in  1  commit feedback valid
- commit_rob_id  in  COMMIT_WIDTH*ROB_ID_WIDTH  committed ids, lane j at [j*ROB_ID_WIDTH +: ROB_ID_WIDTH]
- commit_rob_id_valid  in  COMMIT_WIDTH  per-lane valid
- flush  in  1  pipeline flush (qualified by commit_enable)
- bus_write_req  out  1  drain request
- bus_write_addr  out  ADDR_WIDTH  word-aligned address, low bits 0
- bus_write_strb  out  STRB_WIDTH  byte enables
- bus_write_data  out  DATA_WIDTH  write data
- bus_write_ack  in  1  write done; pops the request's entries
- all_empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- **Reset (rst=0, async):**
  - rptr/wptr = 0; all entry valid/committed bits = 0; combine lock = 0.
  - Outputs during and after reset: bus_write_req=0, all_empty=1, count=0, push_ready=1, fwd_hit_mask=0, fwd_full_hit=0, fwd_data=0.
  - Entry payload is not reset.
- **Pointers:** rptr/wptr are $clog2(DEPTH)+1 bits with a wrap bit; empty = rptr==wptr; full = index bits equal and wrap bits differ; count = wptr-rptr.
- **Push:**
  - Occurs on push_valid && push_ready.
  - Writes the entry at wptr with committed=0; wptr+1 next cycle.
  - No push while full, even if bus_write_ack frees space that same cycle.
  - No push in a flush cycle.
- **Commit:**
  - When commit_enable, any valid entry whose rob_id equals a valid lane id sets committed=1 next cycle.
  - Multiple lanes may match different entries in the same cycle.
- **Flush (commit_enable && flush):**
  - Same-cycle commits count as committed.
  - wptr_next = position of the oldest valid entry that is not committed; if none, wptr is unchanged.
  - Committed entries are never discarded.
  - rptr may advance by ack in the same cycle.
- **Drain:**
  - bus_write_req = !empty && head.committed, and is not gated by flush.
  - Once asserted, addr/strb/data stay stable until ack.
  - bus_write_ack pops 1 entry (2 when combined) the same edge.
  - An ack with no req is ignored.
- **Forwarding:** purely combinational, 0-cycle.
  - Scan valid entries oldest to youngest; for each entry with the same word address, every byte with strb=1 overrides the byte collected so far. The youngest store wins per byte.
  - Committed and uncommitted entries both forward, including the entry being acked this cycle.
  - fwd outputs are ANDed with query_strb.
- **Wrap-around:** entry index = ptr[low bits]; correct across the index wrap, and in-range test uses the wrap bit.

Optional Feature:
- Macro: STBUF_DRAIN_COMBINE_EN.
- With the macro defined, combine is decided when bus_write_req rises (no outstanding request): if head and head+1 are both valid, committed and share a word address, the request is combined.
  - The decision is latched in the combine lock register until ack.
  - Combined request: strb = OR of both; data = per-byte merge with head+1 bytes overriding.
  - Ack pops 2 entries and clears the lock.
  - head+1 committing after req has risen does not change the in-flight request.
- Without the macro: no lock register; every request is a single entry and ack pops 1.

Test Plan:
- **Push/commit/drain:** after reset, push id 3, addr 0x100, strb 0xF, data 0xAABBCCDD; commit id 3 -> next cycle bus_write_req=1, addr 0x100, strb 0xF, data 0xAABBCCDD; ack -> all_empty=1, count=0.
- **Forwarding:** push (0x200, strb 0x3, 0x00001111) then (0x200, strb 0x2, 0x00002200); query 0x200/0xF -> fwd_data 0x00002211, fwd_hit_mask 0x3, fwd_full_hit=0; query strb 0x3 -> fwd_full_hit=1.
- **Flush:**
  - Push ids 1..4; commit ids 1,2 on lanes 0,1 together with flush -> count=2, ids 1,2 drain in order, ids 3,4 never requested.
  - With no committed entries, flush -> all_empty=1 next cycle.
- **Full:** push DEPTH=8 stores -> push_ready=0, count=8; push_valid=1 with ack in the same cycle -> no push, count=7; next cycle push accepted, count=8; pointers wrap and drain order stays FIFO.
- **Multi-lane commit:** COMMIT_WIDTH=2 commits ids 5 and 6 in one cycle -> both entries committed; bus_write_req stays stable until ack with no ack for 3 cycles.
- **Combine (STBUF_DRAIN_COMBINE_EN):** two committed stores to 0x300, strb 0x1 data 0x11 and strb 0x1 data 0x22 -> one request, strb 0x1, data 0x22, ack pops 2; with the macro undefined -> two requests.

Source files
------------

// File: rtl/store_buffer_v2.sv
// Byte-strobe store buffer: in-order stores, commit by ROB id, flush keeps the committed prefix,
// drains to the bus with req/ack and forwards merged bytes to loads. Optional: STBUF_DRAIN_COMBINE_EN.
module store_buffer_v2 #(
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 7,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_valid,
    output logic                                 push_ready,
    input  logic [ROB_ID_WIDTH-1:0]              push_rob_id,
    input  logic [ADDR_WIDTH-1:0]                push_addr,
    input  logic [DATA_WIDTH/8-1:0]              push_strb,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic [ADDR_WIDTH-1:0]                query_addr,
    input  logic [DATA_WIDTH/8-1:0]              query_strb,
    output logic [DATA_WIDTH-1:0]                fwd_data,
    output logic [DATA_WIDTH/8-1:0]              fwd_hit_mask,
    output logic                                 fwd_full_hit,
    input  logic                                 commit_enable,
    input  logic [COMMIT_WIDTH*ROB_ID_WIDTH-1:0] commit_rob_id,
    input  logic [COMMIT_WIDTH-1:0]              commit_rob_id_valid,
    input  logic                                 flush,
    output logic                                 bus_write_req,
    output logic [ADDR_WIDTH-1:0]                bus_write_addr,
    output logic [DATA_WIDTH/8-1:0]              bus_write_strb,
    output logic [DATA_WIDTH-1:0]                bus_write_data,
    input  logic                                 bus_write_ack,
    output logic                                 all_empty,
    output logic [$clog2(DEPTH):0]               count
);
    localparam int SW  = DATA_WIDTH/8;
    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = IW+1;
    localparam int OFF = $clog2(SW);
    localparam logic [ADDR_WIDTH-1:0] AMASK = {ADDR_WIDTH{1'b1}} << OFF;

    logic [PW-1:0] rptr, wptr, cnt, fl_off;
    logic [DEPTH-1:0] cmt, vld, cm_hit;
    logic [DEPTH-1:0][ROB_ID_WIDTH-1:0] e_rob;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] e_addr;
    logic [DEPTH-1:0][SW-1:0] e_strb;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] e_data;
    logic [IW-1:0] head, nxt, fl_idx, fw_idx;
    logic full, empty, push_fire, flush_cyc, fl_found, comb_sel, pop;
    logic [DATA_WIDTH-1:0] fd;
    logic [SW-1:0] fh;

    assign cnt        = wptr - rptr;
    assign count      = cnt;
    assign empty      = (rptr == wptr);
    assign all_empty  = empty;
    assign full       = (wptr[IW-1:0] == rptr[IW-1:0]) && (wptr[IW] != rptr[IW]);
    assign push_ready = !full && !flush;
    assign push_fire  = push_valid && push_ready;
    assign flush_cyc  = commit_enable && flush;
    assign head       = rptr[IW-1:0];
    assign nxt        = head + IW'(1);

    // Validity comes from the pointer window, so wrap is handled by the offset from rptr.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [IW-1:0] off;
        logic [COMMIT_WIDTH-1:0] lm;
        assign off = IW'(g) - head;
        assign vld[g] = ({1'b0, off} < cnt);
        for (genvar j = 0; j < COMMIT_WIDTH; j++) begin : g_lane
            assign lm[j] = commit_rob_id_valid[j] &&
                           (commit_rob_id[j*ROB_ID_WIDTH +: ROB_ID_WIDTH] == e_rob[g]);
        end
        assign cm_hit[g] = commit_enable && vld[g] && (|lm);
    end

    // Oldest entry still uncommitted after this cycle's commits marks the flush point.
    always_comb begin
        fl_found = 1'b0;
        fl_off   = '0;
        fl_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fl_idx = head + IW'(k);
            if (!fl_found && (PW'(k) < cnt) && !(cmt[fl_idx] || cm_hit[fl_idx])) begin
                fl_found = 1'b1;
                fl_off   = PW'(k);
            end
        end
    end

    always_comb begin
        fd     = '0;
        fh     = '0;
        fw_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fw_idx = head + IW'(k);
            if ((PW'(k) < cnt) && (e_addr[fw_idx] == (query_addr & AMASK))) begin
                for (int b = 0; b < SW; b++) begin
                    if (e_strb[fw_idx][b]) begin
                        fd[b*8 +: 8] = e_data[fw_idx][b*8 +: 8];
                        fh[b]        = 1'b1;
                    end
                end
            end
        end
        fwd_hit_mask = fh & query_strb;
        fwd_data     = '0;
        for (int b = 0; b < SW; b++) begin
            if (query_strb[b]) fwd_data[b*8 +: 8] = fd[b*8 +: 8];
        end
        fwd_full_hit = (query_strb != '0) && ((fh & query_strb) == query_strb);
    end

    assign bus_write_req = !empty && cmt[head];
    assign pop           = bus_write_req && bus_write_ack;

`ifdef STBUF_DRAIN_COMBINE_EN
    logic out_q, lock, can_comb;
    assign can_comb = (cnt >= PW'(2)) && cmt[head] && cmt[nxt] && (e_addr[head] == e_addr[nxt]);
    // Decision is taken on the first request cycle and held until ack.
    assign comb_sel = out_q ? lock : can_comb;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= 1'b0;
            lock  <= 1'b0;
        end else if (pop) begin
            out_q <= 1'b0;
            lock  <= 1'b0;
        end else if (bus_write_req) begin
            out_q <= 1'b1;
            lock  <= comb_sel;
        end
    end
`else
    assign comb_sel = 1'b0;
`endif

    always_comb begin
        bus_write_addr = e_addr[head];
        bus_write_strb = e_strb[head];
        bus_write_data = e_data[head];
        if (comb_sel) begin
            bus_write_strb = e_strb[head] | e_strb[nxt];
            for (int b = 0; b < SW; b++) begin
                if (e_strb[nxt][b]) bus_write_data[b*8 +: 8] = e_data[nxt][b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr <= '0;
            wptr <= '0;
            cmt  <= '0;
        end else begin
            if (pop) rptr <= rptr + (comb_sel ? PW'(2) : PW'(1));
            if (flush_cyc) begin
                if (fl_found) wptr <= rptr + fl_off;
            end else if (push_fire) begin
                wptr <= wptr + PW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (cm_hit[i]) cmt[i] <= 1'b1;
                else if (push_fire && (wptr[IW-1:0] == IW'(i))) cmt[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            e_rob[wptr[IW-1:0]]  <= push_rob_id;
            e_addr[wptr[IW-1:0]] <= push_addr & AMASK;
            e_strb[wptr[IW-1:0]] <= push_strb;
            e_data[wptr[IW-1:0]] <= push_data;
        end
    end
endmodule
